// File: rtl/cpu_defs.sv
// Shared pipeline constants for the register-dependency scoreboard.
package cpu_defs;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CNT_W      = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/hazard_cnt.sv
// Per-register outstanding-write counter: saturates at max, holds at zero,
// and flags illegal overflow/underflow in simulation.
module hazard_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         nz
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q != '1) cnt_d = cnt_q + W'(1);
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign nz  = (cnt_q != '0);

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(inc && !dec && !clr && cnt_q == '1))
    else $error("hazard_cnt overflow");
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(dec && !inc && !clr && cnt_q == '0))
    else $error("hazard_cnt underflow");
`endif
endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard and ID stall controller for the five-stage pipeline.
// Optional HAZARD_WB_BYPASS_EN: same-cycle WB write-through clears a last pending write.
module hazard_scoreboard
  import cpu_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_fire,
  input  logic                  id_rf_we,
  input  logic [REG_ADDR_W-1:0] id_rf_waddr,
  input  logic                  id_src1_used,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] id_raddr1,
  input  logic [REG_ADDR_W-1:0] id_raddr2,
  input  logic                  wb_fire,
  input  logic                  wb_rf_we,
  input  logic [REG_ADDR_W-1:0] wb_rf_waddr,
  input  logic                  flush,
  output logic                  stall,
  output logic                  pending_any
);
  logic                 issue;
  logic                 retire;
  logic [NUM_REGS-1:0]  nz;
  logic [NUM_REGS-1:0]  pend;
  logic [CNT_W-1:0]     cnt [NUM_REGS];

  assign issue  = id_fire && id_rf_we && (id_rf_waddr != '0);
  assign retire = wb_fire && wb_rf_we && (wb_rf_waddr != '0);

  assign nz[0]  = 1'b0;
  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    hazard_cnt #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (issue  && (id_rf_waddr == REG_ADDR_W'(r))),
      .dec (retire && (wb_rf_waddr == REG_ADDR_W'(r))),
      .clr (flush),
      .cnt (cnt[r]),
      .nz  (nz[r])
    );
  end

`ifdef HAZARD_WB_BYPASS_EN
  // A register whose only outstanding write retires this cycle is visible through the RF.
  always_comb begin
    pend = nz;
    if (retire && cnt[wb_rf_waddr] == CNT_W'(1)) pend[wb_rf_waddr] = 1'b0;
  end
`else
  assign pend = nz;
`endif

  assign stall = id_valid && ((id_src1_used && pend[id_raddr1]) ||
                              (id_src2_used && pend[id_raddr2]));

  always_comb begin
    pending_any = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (cnt[r] != '0) pending_any = 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table,
// flush/reset corner sequences, and a randomized phase against a counter model.
module tb_hazard_scoreboard;
`ifdef HAZARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 0, id_fire = 0, id_rf_we = 0;
  logic [4:0] id_rf_waddr = '0;
  logic       id_src1_used = 0, id_src2_used = 0;
  logic [4:0] id_raddr1 = '0, id_raddr2 = '0;
  logic       wb_fire = 0, wb_rf_we = 0;
  logic [4:0] wb_rf_waddr = '0;
  logic       flush = 0;
  logic       stall, pending_any;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_fire(id_fire),
    .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .wb_fire(wb_fire), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
    .flush(flush), .stall(stall), .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       idv, fire, we;
    logic [4:0] wa;
    logic       s1u;
    logic [4:0] ra1;
    logic       s2u;
    logic [4:0] ra2;
    logic       wbf, wbwe;
    logic [4:0] wba;
    logic       fl;
    logic       exp_stall, exp_pany;
  } vec_t;

  typedef struct {
    logic  stall, pany;
    string name;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mcnt [32];

  function automatic vec_t mk(logic idv, logic fire, logic we, int wa,
                              logic s1u, int ra1, logic s2u, int ra2,
                              logic wbf, logic wbwe, int wba, logic fl,
                              logic es, logic ep);
    vec_t v;
    v.idv = idv; v.fire = fire; v.we = we; v.wa = 5'(wa);
    v.s1u = s1u; v.ra1 = 5'(ra1); v.s2u = s2u; v.ra2 = 5'(ra2);
    v.wbf = wbf; v.wbwe = wbwe; v.wba = 5'(wba); v.fl = fl;
    v.exp_stall = es; v.exp_pany = ep;
    return v;
  endfunction

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Pops the oldest expectation and compares it with the live outputs.
  task automatic sample();
    exp_t e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: expectation queue empty at %0t", $time);
      return;
    end
    e = exp_q.pop_front();
    check1({e.name, ".stall"}, stall, e.stall);
    check1({e.name, ".pending_any"}, pending_any, e.pany);
    check1({e.name, ".fire_while_stall"}, id_fire & stall, 1'b0);
  endtask

  task automatic drive(vec_t v, string name);
    @(negedge clk);
    id_valid = v.idv; id_fire = v.fire; id_rf_we = v.we; id_rf_waddr = v.wa;
    id_src1_used = v.s1u; id_raddr1 = v.ra1; id_src2_used = v.s2u; id_raddr2 = v.ra2;
    wb_fire = v.wbf; wb_rf_we = v.wbwe; wb_rf_waddr = v.wba; flush = v.fl;
    exp_q.push_back('{stall: v.exp_stall, pany: v.exp_pany, name: name});
    #2;
    sample();
  endtask

  function automatic logic mpend(int r, logic ret, int wba);
    if (r == 0 || mcnt[r] == 0) return 1'b0;
    if (BYP && ret && wba == r && mcnt[r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    vec_t v;
    // idv fire we wa  s1u ra1 s2u ra2  wbf wbwe wba  fl  stall pany
    tbl.push_back(mk(1,0,0,0, 1,5, 0,0, 0,0,0, 0, 0,0));   // no history
    tbl.push_back(mk(1,1,1,5, 0,0, 0,0, 0,0,0, 0, 0,0));   // issue r5
    tbl.push_back(mk(1,0,0,0, 1,5, 0,0, 0,0,0, 0, 1,1));
    tbl.push_back(mk(1,0,0,0, 1,5, 0,0, 0,0,0, 0, 1,1));
    tbl.push_back(mk(1,0,0,0, 1,5, 0,0, 0,0,0, 0, 1,1));
    tbl.push_back(mk(1,0,0,0, 1,5, 0,0, 1,1,5, 0, !BYP,1)); // retire r5
    tbl.push_back(mk(1,0,0,0, 1,5, 0,0, 0,0,0, 0, 0,0));
    tbl.push_back(mk(1,1,1,7, 0,0, 0,0, 0,0,0, 0, 0,0));   // r7 writer 1
    tbl.push_back(mk(1,1,1,7, 0,0, 0,0, 0,0,0, 0, 0,1));   // r7 writer 2
    tbl.push_back(mk(1,0,0,0, 0,0, 1,7, 1,1,7, 0, 1,1));   // retire 1 of 2
    tbl.push_back(mk(1,0,0,0, 0,0, 1,7, 1,1,7, 0, !BYP,1)); // retire last
    tbl.push_back(mk(1,0,0,0, 0,0, 1,7, 0,0,0, 0, 0,0));
    tbl.push_back(mk(1,1,1,9, 0,0, 0,0, 0,0,0, 0, 0,0));   // issue r9
    tbl.push_back(mk(1,1,1,9, 0,0, 0,0, 1,1,9, 0, 0,1));   // issue+retire r9
    tbl.push_back(mk(1,0,0,0, 1,9, 0,0, 0,0,0, 0, 1,1));   // still 1
    tbl.push_back(mk(0,0,0,0, 1,9, 0,0, 1,1,9, 0, 0,1));   // id invalid
    tbl.push_back(mk(1,0,0,0, 1,9, 1,9, 0,0,0, 0, 0,0));
    tbl.push_back(mk(1,1,1,0, 0,0, 0,0, 1,1,0, 0, 0,0));   // r0 writes
    tbl.push_back(mk(1,0,0,0, 1,0, 1,0, 0,0,0, 0, 0,0));
    tbl.push_back(mk(1,1,1,3, 0,0, 0,0, 0,0,0, 0, 0,0));   // issue r3
    tbl.push_back(mk(1,1,1,3, 0,3, 0,3, 0,0,0, 0, 0,1));   // unused srcs
    tbl.push_back(mk(1,0,0,0, 1,3, 0,0, 0,1,3, 0, 1,1));   // wb_fire low

    id_valid = 1; id_src1_used = 1; id_raddr1 = 5'd5;
    #3;
    check1("reset.stall", stall, 1'b0);
    check1("reset.pending_any", pending_any, 1'b0);
    #10 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i], $sformatf("vec%0d", i));

    // cnt[3]=2: flush clears everything on the next edge
    drive(mk(1,0,0,0, 1,3, 0,0, 0,0,0, 1, 1,1), "flush_cycle");
    drive(mk(1,0,0,0, 1,3, 0,0, 0,0,0, 0, 0,0), "after_flush");

    // asynchronous reset while stalled
    drive(mk(1,1,1,4, 0,0, 0,0, 0,0,0, 0, 0,0), "issue_r4");
    drive(mk(1,0,0,0, 1,4, 0,0, 0,0,0, 0, 1,1), "stall_r4");
    rst = 1'b0;
    #1;
    check1("async_reset.stall", stall, 1'b0);
    check1("async_reset.pending_any", pending_any, 1'b0);
    @(negedge clk) rst = 1'b1;
    drive(mk(1,0,0,0, 1,4, 0,0, 0,0,0, 0, 0,0), "after_reset");

    // randomized legal traffic against a counter model
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    for (int n = 0; n < 300; n++) begin
      logic ms, mp;
      int   r;
      v.idv  = 1'($urandom_range(0, 3) != 0);
      v.s1u  = 1'($urandom);
      v.s2u  = 1'($urandom);
      v.ra1  = 5'($urandom_range(0, 7));
      v.ra2  = 5'($urandom_range(0, 7));
      r      = $urandom_range(0, 7);
      v.wbf  = 1'($urandom) && mcnt[r] > 0;
      v.wbwe = v.wbf;
      v.wba  = 5'(r);
      v.fl   = 1'($urandom_range(0, 39) == 0);
      ms = v.idv && ((v.s1u && mpend(int'(v.ra1), v.wbf, r)) ||
                     (v.s2u && mpend(int'(v.ra2), v.wbf, r)));
      mp = 1'b0;
      for (int k = 1; k < 32; k++) if (mcnt[k] != 0) mp = 1'b1;
      v.wa   = 5'($urandom_range(0, 7));
      v.we   = 1'($urandom);
      v.fire = v.idv && !ms && 1'($urandom) &&
               (!v.we || v.wa == 0 || mcnt[v.wa] < 3 || (v.wbf && v.wba == v.wa));
      v.exp_stall = ms;
      v.exp_pany  = mp;
      drive(v, $sformatf("rnd%0d", n));
      if (v.fl) begin
        for (int k = 0; k < 32; k++) mcnt[k] = 0;
      end else begin
        if (v.fire && v.we && v.wa != 0) mcnt[v.wa]++;
        if (v.wbf && v.wba != 0) mcnt[v.wba]--;
      end
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations left unchecked", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-dependency scoreboard and stall controller for the five-stage LoongArch pipeline. Tracks outstanding general-register writes issued from the decode stage until they retire in writeback. Produces the `stall` input of the decode stage (ID readygo = ~stall), so ID holds any instruction whose source registers are still pending. Sits beside ID and observes the ID→EX and WB handshakes.

## Interface
- `NUM_REGS`, 32: architectural general registers; r0 never tracked.
- `CNT_W`, 2: per-register pending counter width; supports up to 3 writes in flight (EX, MEM, WB).
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `id_valid`  in  1  ID holds a valid instruction.
- `id_fire`  in  1  ID→EX transfer this cycle (ID validout & EX allowin).
- `id_rf_we`  in  1  ID instruction writes a register.
- `id_rf_waddr`  in  5  ID destination register.
- `id_src1_used`, `id_src2_used`  in  1 each  ID reads rf_raddr1 / rf_raddr2.
- `id_raddr1`, `id_raddr2`  in  5 each  ID source register numbers.
- `wb_fire`  in  1  valid instruction retiring in WB this cycle.
- `wb_rf_we`  in  1  retiring instruction writes the register file.
- `wb_rf_waddr`  in  5  retiring destination.
- `flush`  in  1  discard all in-flight instructions behind ID.
- `stall`  out  1  to ID; hold the current instruction.
- `pending_any`  out  1  any register has a nonzero counter.

## Operation
- State: `NUM_REGS` counters `cnt[r]`, `CNT_W` bits each; cnt[0] hardwired 0.
- Issue event: `id_fire & id_rf_we & id_rf_waddr != 0` → increment cnt[id_rf_waddr].
- Retire event: `wb_fire & wb_rf_we & wb_rf_waddr != 0` → decrement cnt[wb_rf_waddr].
- Issue and retire on the same register in one cycle: counter unchanged.
- Issue and retire on different registers: both applied.
- `flush` high: all counters cleared next edge; overrides issue/retire in that cycle.
- pending(r) = cnt[r] != 0 (r0 always 0).
- `stall = id_valid & ((id_src1_used & pending(id_raddr1)) | (id_src2_used & pending(id_raddr2)))`.
- Destination-only hazard (WAW) does not stall; counters handle multiple writers.
- Counter overflow (increment at max) and underflow (decrement at 0) are illegal; simulation assertion fires, hardware saturates / holds at 0.
- `pending_any` = OR of all counters != 0.

## Timing
- Reset (rst low, asynchronous): all counters 0; `stall` = 0, `pending_any` = 0 combinationally thereafter.
- Counters update on rising `clk`; `stall` is combinational from registered counters and current ID fields, zero-cycle latency.
- Producer issued in cycle t: consumer in ID at t+1 sees stall until the cycle after producer's retire edge.
- `id_fire` is never asserted while `stall` is high (ID readygo low); bench checks this.
- Reset mid-operation: counters clear immediately regardless of pending events.

## Configuration
- `HAZARD_WB_BYPASS_EN`: when defined, a source register equal to `wb_rf_waddr` with a qualifying retire event in the same cycle and cnt == 1 is treated as not pending (register file write-through), saving one stall cycle. When undefined, stall persists until the counter reaches 0 at the edge.

## Structure
- Shared package `cpu_defs`: `NUM_REGS`, `REG_ADDR_W` (5), `CNT_W` constant.
- One sub-module `hazard_cnt`: single up/down counter with inc, dec, clr, async active-low reset, and `nz` output; instantiated per register 1..31 via generate.

## Test plan
- Reset then `id_valid=1, src1 r5`, no history → stall=0, pending_any=0.
- Issue add to r5 (id_fire, waddr=5); next cycle ID reads r5 → stall=1 for 3 cycles; WB retire r5 → stall=0 the cycle after (same cycle with `HAZARD_WB_BYPASS_EN`).
- Issue two writers to r7 back-to-back → cnt[7]=2; first retire → still stall; second retire → stall=0.
- Same-cycle issue to r9 and retire from r9 with cnt[9]=1 → cnt[9] stays 1, stall on r9 remains.
- Writes to r0 issued/retired → cnt never changes, reading r0 never stalls.
- cnt[3]=2, assert `flush` → next cycle cnt[3]=0, pending_any=0; rst low mid-stall → stall=0 immediately.
